// File: rtl/mod_sched_pkg.sv
// Shared types and constants for the mod_scheduler shared divider slice.
package mod_sched_pkg;

  localparam int K_DEF = 4;
  localparam int CNT_W = $clog2(K_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/mod_scheduler_if.sv
// Request/response bundle between two requesters, the scheduler and its consumer.
interface mod_sched_if #(parameter int K = 4);

  logic         req0_valid;
  logic         req0_ready;
  logic [K-1:0] req0_a;
  logic [K-1:0] req0_b;
  logic         req1_valid;
  logic         req1_ready;
  logic [K-1:0] req1_a;
  logic [K-1:0] req1_b;
  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic [K-1:0] rsp_quot;
  logic [K-1:0] rsp_rem;
  logic         rsp_err;

  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req1_valid, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_quot, rsp_rem, rsp_err
  );

  modport master (
    output req0_valid, req0_a, req0_b,
    output req1_valid, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_quot, rsp_rem, rsp_err
  );

endinterface

// File: rtl/mod_div_core.sv
// Iterative restoring divider: one quotient bit per cycle, B == 0 resolved at start.
module mod_div_core
  import mod_sched_pkg::*;
#(
  parameter int K = K_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [K-1:0] a_i,
  input  logic [K-1:0] b_i,
  output logic         last_o,
  output logic [K-1:0] quot_o,
  output logic [K-1:0] rem_o,
  output logic         err_o
);

  localparam int CW = $clog2(K);

  logic [K:0]    r_q, r_d;
  logic [K-1:0]  q_q, q_d;
  logic [K-1:0]  b_q, b_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;

  logic [K:0]    r_sh_s;
  logic [K:0]    r_sub_s;
  logic          ge_s;

  // r_q[K] is zero between steps; OR-ing it in keeps the full remainder register in use.
  assign r_sh_s  = {r_q[K-1:0], q_q[K-1]};
  assign ge_s    = r_q[K] | (r_sh_s >= {1'b0, b_q});
  assign r_sub_s = r_sh_s - {1'b0, b_q};

  always_comb begin
    r_d    = r_q;
    q_d    = q_q;
    b_d    = b_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    err_d  = err_q;
    if (busy_q) begin
      if (ge_s) begin
        r_d = r_sub_s;
        q_d = {q_q[K-2:0], 1'b1};
      end else begin
        r_d = r_sh_s;
        q_d = {q_q[K-2:0], 1'b0};
      end
      if (cnt_q == {CW{1'b0}}) begin
        busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
      end
    end else if (start_i) begin
      b_d = b_i;
      if (b_i == {K{1'b0}}) begin
        q_d   = {K{1'b1}};
        r_d   = {1'b0, a_i};
        err_d = 1'b1;
      end else begin
        q_d    = a_i;
        r_d    = {(K+1){1'b0}};
        err_d  = 1'b0;
        cnt_d  = CW'(K-1);
        busy_d = 1'b1;
      end
    end else begin
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q    <= {(K+1){1'b0}};
      q_q    <= {K{1'b0}};
      b_q    <= {K{1'b0}};
      cnt_q  <= {CW{1'b0}};
      busy_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      r_q    <= r_d;
      q_q    <= q_d;
      b_q    <= b_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  assign last_o = busy_q && (cnt_q == {CW{1'b0}});
  assign quot_o = q_q;
  assign rem_o  = r_q[K-1:0];
  assign err_o  = err_q;

endmodule

// File: rtl/mod_scheduler.sv
// Round-robin arbiter and request/response FSM in front of one shared divider.
module mod_scheduler
  import mod_sched_pkg::*;
#(
  parameter int K = K_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  mod_sched_if.slave    bus
);

  state_e       state_q, state_d;
  logic         rr_last_q, rr_last_d;
  logic         id_q, id_d;

  logic         grant_s;
  logic         ready0_s, ready1_s;
  logic         hs_s;
  logic         rsp_valid_s;
  logic [K-1:0] a_sel_s, b_sel_s;
  logic         last_s;
  logic [K-1:0] quot_s, rem_s;
  logic         err_s;

  // On a tie the requester that was not granted last wins.
  always_comb begin
    if (bus.req0_valid && bus.req1_valid) begin
      grant_s = ~rr_last_q;
    end else if (bus.req1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  assign a_sel_s = grant_s ? bus.req1_a : bus.req0_a;
  assign b_sel_s = grant_s ? bus.req1_b : bus.req0_b;
  assign hs_s    = (bus.req0_valid && ready0_s) || (bus.req1_valid && ready1_s);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rr_last_q <= 1'b1;
      id_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      id_q      <= id_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    id_d      = id_q;
    case (state_q)
      IDLE: begin
        if (hs_s) begin
          rr_last_d = grant_s;
          id_d      = grant_s;
          if (b_sel_s == {K{1'b0}}) begin
            state_d = RESP;
          end else begin
            state_d = CALC;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        if (last_s) begin
          state_d = RESP;
        end else begin
          state_d = CALC;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Ready is gated by rst_n so nothing is offered while reset is held.
  always_comb begin
    ready0_s    = 1'b0;
    ready1_s    = 1'b0;
    rsp_valid_s = 1'b0;
    case (state_q)
      IDLE: begin
        ready0_s = rst_n && bus.req0_valid && !grant_s;
        ready1_s = rst_n && bus.req1_valid && grant_s;
      end
      CALC: begin
        rsp_valid_s = 1'b0;
      end
      RESP: begin
        rsp_valid_s = 1'b1;
      end
      default: begin
        rsp_valid_s = 1'b0;
      end
    endcase
  end

  mod_div_core #(.K(K)) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (hs_s),
    .a_i     (a_sel_s),
    .b_i     (b_sel_s),
    .last_o  (last_s),
    .quot_o  (quot_s),
    .rem_o   (rem_s),
    .err_o   (err_s)
  );

  assign bus.req0_ready = ready0_s;
  assign bus.req1_ready = ready1_s;
  assign bus.rsp_valid  = rsp_valid_s;
  assign bus.rsp_id     = id_q;
  assign bus.rsp_quot   = quot_s;
  assign bus.rsp_rem    = rem_s;
  assign bus.rsp_err    = err_s;

endmodule

// File: doc/mod_scheduler.md
# mod_scheduler

Shared-resource controller for the calculator's modulus path. Two requesters submit (A, B) operand pairs over valid/ready handshakes. A round-robin arbiter grants one request at a time to a single iterative restoring divider. The divider returns quotient, remainder and a divide-by-zero error flag on a response channel tagged with the requester ID. It replaces per-requester combinational mod units, trading latency for one shared datapath.

## Interface
Parameters:
- K, 4, operand/result width in bits (K ≥ 2)

Ports:
- clk  input  1  single clock; everything is on its rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- req0_valid  input  1  requester 0 has an operand pair.
- req0_ready  output  1  requester 0 request accepted this cycle.
- req0_a, req0_b  input  K each  requester 0 dividend and divisor.
- req1_valid, req1_ready, req1_a, req1_b  same as requester 0, for requester 1.
- rsp_valid  output  1  response fields are valid.
- rsp_ready  input  1  consumer accepts the response.
- rsp_id  output  1  index of the requester that owns the response.
- rsp_quot  output  K  A / B.
- rsp_rem  output  K  A % B.
- rsp_err  output  1  1 when B was 0.

## Operation
- FSM states are IDLE, CALC and RESP.
- **IDLE:**
  - reqN_ready is combinationally asserted only in IDLE and only for the granted requester.
  - If only one requester is valid, it is granted.
  - If both are valid, grant goes to the requester not granted last. After reset, req0 wins the first tie.
  - Handshake is reqN_valid & reqN_ready. On handshake the block latches A, B and id, and updates the round-robin pointer.
  - If B == 0, go to RESP with quot = all ones, rem = A, err = 1.
  - Otherwise clear the remainder register (K+1 bits), load quot ← A, set step counter ← K-1, and go to CALC.
- **CALC:** one restoring step per cycle.
  - r ← {r[K-1:0], q[K-1]}, then q ← q << 1.
  - If r ≥ {0,B}: r ← r − B and q[0] ← 1.
  - After the step with counter = 0, go to RESP. Otherwise decrement the counter.
- **RESP:**
  - rsp_valid = 1. rsp_quot, rsp_rem, rsp_err and rsp_id are held stable until rsp_valid & rsp_ready.
  - On that handshake, go to IDLE.
  - No request is accepted while in RESP, including in the handshake cycle itself.
- Unsigned arithmetic throughout. rsp_rem is the low K bits of r; the top bit is always 0 at completion.
- Requesters that are not granted keep valid asserted. Their operands must stay stable; this block does not buffer them.

## Timing
- Reset values:
  - FSM = IDLE, round-robin pointer = "req1 last".
  - rsp_valid = 0, rsp_id = 0, rsp_quot = 0, rsp_rem = 0, rsp_err = 0.
  - req0_ready and req1_ready = 0 while rst_n is low.
- Assertion of rst_n at any state, including mid-CALC or RESP with rsp_ready low, immediately aborts the operation and returns these values. No response is emitted for the aborted request.
- Request handshake in cycle T, B ≠ 0: CALC occupies cycles T+1 … T+K, and rsp_valid rises at T+K+1.
- Request handshake in cycle T, B = 0: rsp_valid rises at T+1.
- With rsp_ready held high, the response handshake completes in its first valid cycle and the next request can be accepted one cycle later.
  - Throughput is one request per K+2 cycles for B ≠ 0.
  - Throughput is one request per 2 cycles for B = 0.
- Backpressure: rsp_valid stays high and outputs stay frozen for any number of cycles while rsp_ready is low.

## Structure
- Package mod_sched_pkg:
  - state enum {IDLE, CALC, RESP}
  - K default constant
  - step-counter width localparam, $clog2(K)
- Sub-module mod_div_core holds the iterative datapath:
  - r and q registers, step counter
  - start/done interface
  - err detection for B == 0
- mod_scheduler holds:
  - the arbiter and round-robin pointer
  - the FSM
  - the request and response handshakes
  - the id register

## Test plan
- **Single request:** req0 sends A=4'b1111, B=4'b1010 → after K+1 cycles, rsp_id=0, quot=1, rem=5, err=0.
- **Divide by zero:** req1 sends A=15, B=0 → rsp_valid one cycle after accept, with rsp_id=1, quot=4'b1111, rem=15, err=1.
- **Contention:** req0 and req1 both valid continuously after reset.
  - Grants go 0, 1, 0, 1.
  - Responses are tagged in the same order.
  - Neither requester sees ready while the other's operation is in flight.
- **Backpressure:** rsp_ready held low for 5 cycles during RESP.
  - Outputs stay stable.
  - No reqN_ready is asserted.
  - Raising rsp_ready completes the transfer, and the next accept happens one cycle later.
- **Exhaustive check:** all 256 (A, B) pairs through req0 → quot/rem match A/B and A%B for B ≠ 0, and the B = 0 rule otherwise.
- **Reset mid-operation:** rst_n pulsed low at CALC step 2.
  - All outputs return to reset values asynchronously.
  - No stale response appears.
  - The next request completes correctly.
